inst_queue: RTL and testbench
=============================

# inst_queue

Dual-issue instruction fetch queue directly upstream of the decode-stage `twinflop` pipeline register. It accepts up to two fetched instructions per cycle in program order and buffers them in a circular store. It presents the two oldest entries to decode, and retires 0, 1 or 2 of them per cycle according to the same `can_proceed[2]` stall vector that drives the downstream register. This decouples fetch bandwidth from decode stalls.

## Interface
Parameters:
- `DEPTH`, 8, number of entries; power of two, ≥ 4
- `XLEN`, 32, width of instruction word and PC

Ports:
- `clk`  in  1  clock; all state updates on the falling edge of `clk`
- `reset`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous discard of all entries (branch redirect)
- `in_valid[2]`  in  1 each  fetch slot valid; slot 1 is ignored unless slot 0 is valid
- `in_inst[2]`  in  XLEN each  fetched instruction words, slot 0 oldest
- `in_pc[2]`  in  XLEN each  PCs of the fetched words
- `in_ready`  out  1  queue accepts this cycle's fetch group
- `out_valid[2]`  out  1 each  head entries valid
- `out_inst[2]`  out  XLEN each  oldest (slot 0) and second-oldest (slot 1) instruction
- `out_pc[2]`  out  XLEN each  matching PCs
- `can_proceed[2]`  in  1 each  decode acceptance, same semantics as the pipeline register

## Operation
- State: `head`, `tail` (log2(DEPTH) bits, wrap modulo DEPTH), `count` (log2(DEPTH)+1 bits, 0..DEPTH), entry array of {pc, inst}.
- `in_ready = (DEPTH - count) >= 2`. It is computed from registered `count` only, and same-cycle pops are not credited.
- Push count `npush` = 0 if `!in_ready` or `!in_valid[0]`. Otherwise `npush` = 1 + `in_valid[1]`. Entries are written at `tail` and `tail+1`, and `tail` advances by `npush`.
- Request `req` = 0 if `!can_proceed[0]`, 1 if `can_proceed[0] && !can_proceed[1]`, 2 if both. Pop count `npop = min(req, visible valid)`. `head` advances by `npop`.
- `count_next = count + npush - npop`. Simultaneous push and pop is legal at every occupancy, including full-minus-2 and empty.
- Outputs: `out_valid[0] = count >= 1`, `out_valid[1] = count >= 2`. Slot data comes from entries `head` and `head+1`. Data on an invalid slot is don't-care.
- `flush` or `reset`: `head = tail = count = 0`. These take priority over any same-cycle push or pop, and the fetch group presented in that cycle is dropped. Entry contents are not cleared.
- Program order is preserved. Slot 0 is always older than slot 1, and no entry is duplicated or skipped across wrap-around.

## Timing
- Reset values: `in_ready = 1`, `out_valid = {0,0}`, and out data don't-care. Everything is cleared one falling edge after `reset` is sampled high.
- Without bypass, fetch-to-output latency is 1 edge. An instruction pushed at edge N is visible on `out_*` after edge N.
- `in_ready` and `out_valid` depend only on registered state. There is no combinational path from `can_proceed` to `in_ready`.
- Reset asserted mid-operation discards all contents on the next edge. `in_ready` is high from that edge on.

## Configuration
- `INST_QUEUE_BYPASS_EN` defined: the output view is the first two valid items of the sequence {queued entries, accepted incoming entries}. When `count` is 0 or 1, accepted fetch entries appear on `out_*` in the same cycle. The pop count applies to that combined view, and only incoming entries not popped are written. `in_ready` remains unchanged. Latency through an empty queue is 0.
- Undefined: there is no combinational path from `in_*` to `out_*`, and latency is exactly 1 edge.

## Structure
- Shared package `r2rv_pkg`: `inst_t` (logic [XLEN-1:0]), `fetch_entry_t` struct {pc, inst}, and a `XLEN` constant.
- No sub-module is required. The `head`/`tail`/`count` registers instantiate the existing `flopr` for uniform negedge, synchronous-reset behaviour. The entry array is a plain negedge `always_ff` without reset.

## Test plan
- Reset, then push {pc 0x0, 0x4} with `can_proceed` = {0,0} → after 1 edge, `out_valid` = {1,1`, `out_pc` = {0x0, 0x4}, `count` = 2.
- Fill to DEPTH=8 with pairs and no pops → `in_ready` drops at `count` = 7 or 8. A push presented while `in_ready` = 0 does not change `count` or `tail`.
- With 3 entries (pc 0x10, 0x14, 0x18), `can_proceed` = {1,0} → next `out_pc[0]` = 0x14, `out_pc[1]` = 0x18. With {1,1} → `out_pc[0]` = 0x18 and `out_valid[1]` = 0.
- Wrap-around: repeatedly push 2 and pop 2 for 20 cycles → PCs emerge strictly increasing by 4 with no gaps, and `head` and `tail` wrap past 7.
- `flush` together with push and `can_proceed` = {1,1}, with 5 entries queued → next cycle `count` = 0, `out_valid` = {0,0}, `in_ready` = 1.
- With `INST_QUEUE_BYPASS_EN` and the queue empty, push {0x40, 0x44} with `can_proceed` = {1,0} → in the same cycle `out_pc[0]` = 0x40. After the edge, `count` = 1 and `out_pc[0]` = 0x44.

Source files
------------

// File: rtl/r2rv_pkg.sv
// Shared fetch/decode types: instruction word, fetch entry record and the
// small 0..2 slot-count type used by the dual-issue front end.
package r2rv_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] inst_t;

  typedef struct packed {
    inst_t pc;
    inst_t inst;
  } fetch_entry_t;

  // Number of slots moved in one cycle (0, 1 or 2).
  typedef logic [1:0] slot_cnt_t;

  function automatic slot_cnt_t min_slots(input slot_cnt_t a, input slot_cnt_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/flopr.sv
// Resettable register clocked on the falling edge, synchronous active-high reset.
module flopr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Falling-edge state with synchronous clear.
  always_ff @(negedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/inst_queue.sv
// Dual-issue instruction fetch queue in front of the decode pipeline register.
// Accepts up to two fetched words per cycle, presents the two oldest to decode
// and retires 0..2 of them per cycle from the can_proceed stall vector.
// All state changes on the falling edge of clk.
//
// Optional build macro INST_QUEUE_BYPASS_EN: accepted fetch entries are
// visible on out_* in the same cycle when fewer than two entries are queued,
// and entries popped straight from the fetch group are never written.
//
// Handshake: a fetch group is taken when in_ready && in_valid[0]; in_valid[1]
// only extends it. Decode takes slot 0 when can_proceed[0], and slot 1 as well
// when both bits are set; only out_valid slots are actually retired.
// count/head/tail are exported for observation.
module inst_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [1:0]               in_valid,
  input  logic [XLEN-1:0]          in_inst [2],
  input  logic [XLEN-1:0]          in_pc [2],
  output logic                     in_ready,
  output logic [1:0]               out_valid,
  output logic [XLEN-1:0]          out_inst [2],
  output logic [XLEN-1:0]          out_pc [2],
  input  logic [1:0]               can_proceed,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH)-1:0] head,
  output logic [$clog2(DEPTH)-1:0] tail
);
  import r2rv_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  entry_t mem [DEPTH];

  logic [CW-1:0] count_next;
  logic [AW-1:0] head_next, tail_next;
  logic [AW-1:0] head_p1, tail_p1;
  slot_cnt_t     npush, req, qvis, vis, npop, popq, nwrite;
  entry_t        in_e0, in_e1, wr_e0;
`ifdef INST_QUEUE_BYPASS_EN
  logic [2:0]    vsum;
  slot_cnt_t     pop_in;
`endif

  assign head_p1 = head + AW'(1);
  assign tail_p1 = tail + AW'(1);
  assign in_e0   = '{pc: in_pc[0], inst: in_inst[0]};
  assign in_e1   = '{pc: in_pc[1], inst: in_inst[1]};

  // Credit check uses registered count only; same-cycle pops are not counted.
  assign in_ready = (count <= CW'(DEPTH - 2));

  // Push/pop arithmetic and next-state pointers.
  always_comb begin
    npush = 2'd0;
    if (in_ready && in_valid[0]) npush = in_valid[1] ? 2'd2 : 2'd1;

    req = 2'd0;
    if (can_proceed[0]) req = can_proceed[1] ? 2'd2 : 2'd1;

    qvis = (count >= CW'(2)) ? 2'd2 : {1'b0, count[0]};

`ifdef INST_QUEUE_BYPASS_EN
    vsum   = {1'b0, qvis} + {1'b0, npush};
    vis    = (vsum >= 3'd2) ? 2'd2 : vsum[1:0];
    npop   = min_slots(req, vis);
    popq   = min_slots(npop, qvis);
    pop_in = npop - popq;
    nwrite = npush - pop_in;
    wr_e0  = (pop_in == 2'd1) ? in_e1 : in_e0;
`else
    vis    = qvis;
    npop   = min_slots(req, vis);
    popq   = npop;
    nwrite = npush;
    wr_e0  = in_e0;
`endif

    count_next = count + CW'(npush) - CW'(npop);
    head_next  = head + AW'(popq);
    tail_next  = tail + AW'(nwrite);

    // A flush drops everything, including this cycle's fetch group.
    if (flush) begin
      count_next = '0;
      head_next  = '0;
      tail_next  = '0;
    end
  end

  flopr #(.WIDTH(CW)) u_count (.clk(clk), .reset(reset), .d(count_next), .q(count));
  flopr #(.WIDTH(AW)) u_head  (.clk(clk), .reset(reset), .d(head_next),  .q(head));
  flopr #(.WIDTH(AW)) u_tail  (.clk(clk), .reset(reset), .d(tail_next),  .q(tail));

  // Entry storage: written at tail/tail+1, never cleared.
  always_ff @(negedge clk) begin
    if (!reset && !flush) begin
      if (nwrite != 2'd0) mem[tail]    <= wr_e0;
      if (nwrite == 2'd2) mem[tail_p1] <= in_e1;
    end
  end

  // Decode view: two oldest items, slot 0 older than slot 1.
  always_comb begin
    out_valid   = {vis == 2'd2, vis != 2'd0};
    out_pc[0]   = mem[head].pc;
    out_inst[0] = mem[head].inst;
    out_pc[1]   = mem[head_p1].pc;
    out_inst[1] = mem[head_p1].inst;
`ifdef INST_QUEUE_BYPASS_EN
    if (count == '0) begin
      out_pc[0]   = in_e0.pc;
      out_inst[0] = in_e0.inst;
      out_pc[1]   = in_e1.pc;
      out_inst[1] = in_e1.inst;
    end else if (count == CW'(1)) begin
      out_pc[1]   = in_e0.pc;
      out_inst[1] = in_e0.inst;
    end
`endif
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue (DEPTH 8, XLEN 32). State changes on the
// falling edge; outputs are sampled 1 time unit after it.
module tb_inst_queue;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [1:0]  in_valid;
  logic [31:0] in_inst [2];
  logic [31:0] in_pc [2];
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [31:0] out_inst [2];
  logic [31:0] out_pc [2];
  logic [1:0]  can_proceed;
  logic [3:0]  count;
  logic [2:0]  head;
  logic [2:0]  tail;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] exp_q [$];

  inst_queue #(.DEPTH(8), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .can_proceed(can_proceed), .count(count), .head(head), .tail(tail)
  );

  // Clock
  initial clk = 1'b1;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a fetch group of n (0..2) words starting at pc.
  task automatic drive(input logic [31:0] pc, input int n);
    in_valid   = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
    in_pc[0]   = pc;
    in_pc[1]   = pc + 32'd4;
    in_inst[0] = inst_of(pc);
    in_inst[1] = inst_of(pc + 32'd4);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; can_proceed = 2'b00;
    drive(32'h0, 0);
    tick();
    reset = 1'b0;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 2'b00);
    chk("reset_count", count, 0);

    // First pair, no pops: visible after one edge.
    drive(32'h0, 2); tick();
    chk("first_valid", out_valid, 2'b11);
    chk("first_pc0", out_pc[0], 32'h0);
    chk("first_pc1", out_pc[1], 32'h4);
    chk("first_inst0", out_inst[0], inst_of(32'h0));
    chk("first_count", count, 2);

    // Fill to full.
    drive(32'h8, 2);  tick(); chk("fill_count4", count, 4);
    drive(32'h10, 2); tick(); chk("fill_count6", count, 6);
    chk("fill_ready6", in_ready, 1);
    drive(32'h18, 2); tick(); chk("fill_count8", count, 8);
    chk("full_ready", in_ready, 0);
    drive(32'h20, 2); tick();
    chk("full_push_count", count, 8);
    chk("full_push_tail", tail, 0);
    chk("full_pc0", out_pc[0], 32'h0);

    // in_ready drops at 7.
    drive(32'h0, 0); flush = 1'b1; tick(); flush = 1'b0;
    drive(32'h0, 2); tick();
    drive(32'h8, 2); tick();
    drive(32'h10, 2); tick();
    drive(32'h18, 1); tick();
    chk("seven_count", count, 7);
    chk("seven_ready", in_ready, 0);

    // Three entries, pop one.
    drive(32'h0, 0); flush = 1'b1; tick(); flush = 1'b0;
    drive(32'h10, 2); tick();
    drive(32'h18, 1); tick();
    chk("three_count", count, 3);
    drive(32'h0, 0); can_proceed = 2'b01; tick();
    chk("pop1_pc0", out_pc[0], 32'h14);
    chk("pop1_pc1", out_pc[1], 32'h18);
    chk("pop1_count", count, 2);

    // Three entries, pop two.
    can_proceed = 2'b00; flush = 1'b1; tick(); flush = 1'b0;
    drive(32'h10, 2); tick();
    drive(32'h18, 1); tick();
    drive(32'h0, 0); can_proceed = 2'b11; tick();
    chk("pop2_pc0", out_pc[0], 32'h18);
    chk("pop2_valid", out_valid, 2'b01);
    // Request of two with only one entry retires just that one.
    tick();
    chk("pop_over_count", count, 0);
    chk("pop_over_valid", out_valid, 2'b00);

    // Slot 1 without slot 0 is ignored; can_proceed[1] alone pops nothing.
    can_proceed = 2'b00;
    in_valid = 2'b10; tick();
    chk("slot1_only_count", count, 0);
    drive(32'h30, 1); tick();
    drive(32'h0, 0); can_proceed = 2'b10; tick();
    chk("cp1_only_count", count, 1);
    chk("cp1_only_pc0", out_pc[0], 32'h30);

    // Wrap-around: steady push 2 / pop 2 with an expected-PC queue.
    can_proceed = 2'b00; flush = 1'b1; tick(); flush = 1'b0;
    drive(32'h100, 2); tick();
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    for (int k = 1; k <= 20; k++) begin
      drive(32'h100 + 32'(8 * k), 2);
      can_proceed = 2'b11;
      tick();
      void'(exp_q.pop_front()); void'(exp_q.pop_front());
      exp_q.push_back(32'h100 + 32'(8 * k));
      exp_q.push_back(32'h104 + 32'(8 * k));
      chk("wrap_pc0", out_pc[0], exp_q[0]);
      chk("wrap_pc1", out_pc[1], exp_q[1]);
      chk("wrap_count", count, 2);
    end
    chk("wrap_head", head, 0);
    chk("wrap_tail", tail, 2);

    // Flush beats push and pop.
    drive(32'h0, 0); can_proceed = 2'b00; flush = 1'b1; tick(); flush = 1'b0;
    drive(32'h200, 2); tick();
    drive(32'h208, 2); tick();
    drive(32'h210, 1); tick();
    chk("pre_flush_count", count, 5);
    drive(32'h220, 2); can_proceed = 2'b11; flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 2'b00);
    chk("flush_ready", in_ready, 1);

    // Reset mid-operation.
    drive(32'h300, 2); can_proceed = 2'b00; tick();
    chk("pre_reset_count", count, 2);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midreset_count", count, 0);
    chk("midreset_ready", in_ready, 1);
    chk("midreset_valid", out_valid, 2'b00);

    // Push into an empty queue while decode takes one slot.
    drive(32'h40, 2); can_proceed = 2'b01;
    #1;
`ifdef INST_QUEUE_BYPASS_EN
    chk("bypass_same_valid", out_valid, 2'b11);
    chk("bypass_same_pc0", out_pc[0], 32'h40);
    tick();
    chk("bypass_count", count, 1);
    chk("bypass_pc0", out_pc[0], 32'h44);
`else
    chk("nobypass_same_valid", out_valid, 2'b00);
    tick();
    chk("nobypass_count", count, 2);
    chk("nobypass_pc0", out_pc[0], 32'h40);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
